// File: rtl/disp_scan_driver.sv
// Purpose: 4-digit common-anode 7-segment scan driver; double-buffered hex/points/blank, per-digit slots of SCAN_DIV cycles.
// Latency: outputs registered, one cycle behind the internal digit index; loads commit at the next frame wrap.
// Backpressure: none; load is a one-cycle strobe, last load before a wrap wins.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   load              strobe: capture data/points/blank_mask into the pending buffer
//   data[15:0]        hex value, digit k = data[4k+3:4k], digit 0 rightmost
//   points[3:0]       decimal point request per digit (1 = lit)
//   blank_mask[3:0]   forced blank per digit (1 = blank)
//   zero_blank        live level: suppress leading zeros on digits 3..1
//   hex[3:0]          nibble to the decoder D3..D0
//   point             decoder point input (1 = dp lit)
//   LE                decoder LE (1 = all segments off)
//   AN[3:0]           active-low anode select
//   frame_tick        one-cycle pulse in the cycle after a digit 3->0 wrap
module disp_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  points,
    input  logic [3:0]  blank_mask,
    input  logic        zero_blank,
    output logic [3:0]  hex,
    output logic        point,
    output logic        LE,
    output logic [3:0]  AN,
    output logic        frame_tick
);

    localparam int             CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);

    // scan position
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    // pending (written by load) and active (displayed) buffers
    logic [15:0]   pend_data_q, pend_data_d;
    logic [3:0]    pend_pts_q, pend_pts_d;
    logic [3:0]    pend_blank_q, pend_blank_d;
    logic          pend_vld_q, pend_vld_d;
    logic [15:0]   act_data_q, act_data_d;
    logic [3:0]    act_pts_q, act_pts_d;
    logic [3:0]    act_blank_q, act_blank_d;

    // registered outputs
    logic [3:0]    hex_q, hex_d;
    logic          point_q, point_d;
    logic          le_q, le_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q, tick_d;

    logic          cnt_last;
    logic          wrap;
    logic [3:0]    cur_nib;
    logic [3:0]    zb_vec;

    always_comb begin
        cnt_last = (cnt_q == CNT_MAX);
        wrap     = cnt_last && (idx_q == 2'd3);

        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        idx_d = cnt_last ? idx_q + 2'd1 : idx_q;

        pend_data_d  = pend_data_q;
        pend_pts_d   = pend_pts_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;
        if (load) begin
            pend_data_d  = data;
            pend_pts_d   = points;
            pend_blank_d = blank_mask;
            pend_vld_d   = 1'b1;
        end

        // Commit only at the frame boundary. A load landing in the wrap
        // cycle bypasses the pending buffer so it is not a frame late.
        act_data_d  = act_data_q;
        act_pts_d   = act_pts_q;
        act_blank_d = act_blank_q;
        if (wrap) begin
            pend_vld_d = 1'b0;
            if (load) begin
                act_data_d  = data;
                act_pts_d   = points;
                act_blank_d = blank_mask;
            end else if (pend_vld_q) begin
                act_data_d  = pend_data_q;
                act_pts_d   = pend_pts_q;
                act_blank_d = pend_blank_q;
            end
        end

        // Digit k is a leading zero when nibbles k..3 are all zero.
        // Digit 0 always shows, so a value of 0 still displays "0".
        zb_vec[3] = (act_data_q[15:12] == 4'h0);
        zb_vec[2] = zb_vec[3] && (act_data_q[11:8] == 4'h0);
        zb_vec[1] = zb_vec[2] && (act_data_q[7:4]  == 4'h0);
        zb_vec[0] = 1'b0;
        zb_vec    = zb_vec & {4{zero_blank}};

        cur_nib = act_data_q[{idx_q, 2'b00} +: 4];

        an_d    = ~(4'b0001 << idx_q);
        hex_d   = cur_nib;
        le_d    = act_blank_q[idx_q] | zb_vec[idx_q];
        // zero suppression deliberately leaves the point alone
        point_d = act_pts_q[idx_q] & ~act_blank_q[idx_q];
        tick_d  = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            pend_data_q  <= '0;
            pend_pts_q   <= '0;
            pend_blank_q <= '0;
            pend_vld_q   <= 1'b0;
            act_data_q   <= '0;
            act_pts_q    <= '0;
            act_blank_q  <= '0;
            hex_q        <= 4'h0;
            point_q      <= 1'b0;
            le_q         <= 1'b1;
            an_q         <= 4'b1111;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_pts_q   <= pend_pts_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            act_data_q   <= act_data_d;
            act_pts_q    <= act_pts_d;
            act_blank_q  <= act_blank_d;
            hex_q        <= hex_d;
            point_q      <= point_d;
            le_q         <= le_d;
            an_q         <= an_d;
            tick_q       <= tick_d;
        end
    end

    assign hex        = hex_q;
    assign point      = point_q;
    assign LE         = le_q;
    assign AN         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Purpose: directed self-check of disp_scan_driver with SCAN_DIV=4 (16-cycle frames).
// Latency: expects outputs one cycle after state; loads visible in the window after the commit wrap.
// Backpressure: n/a; stimulus is a fixed cycle schedule.
module tb_disp_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  points;
    logic [3:0]  blank_mask;
    logic        zero_blank;
    logic [3:0]  hex;
    logic        point;
    logic        LE;
    logic [3:0]  AN;
    logic        frame_tick;

    int n_chk;
    int n_pass;

    disp_scan_driver #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .points     (points),
        .blank_mask (blank_mask),
        .zero_blank (zero_blank),
        .hex        (hex),
        .point      (point),
        .LE         (LE),
        .AN         (AN),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // advance one edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " AN"},   {28'd0, AN},        32'hF);
        chk({tag, " hex"},  {28'd0, hex},       32'h0);
        chk({tag, " LE"},   {31'd0, LE},        32'h1);
        chk({tag, " pt"},   {31'd0, point},     32'h0);
        chk({tag, " tick"}, {31'd0, frame_tick},32'h0);
    endtask

    // One 16-edge output window, aligned so step 0 is the first digit-0 cycle.
    // Optional loads are sampled at the edge of step at0 / at1 (-1 = none).
    task automatic check_window(input int w,
                                input logic [15:0] exp_data, input logic [3:0] exp_le,
                                input logic [3:0] exp_pt,
                                input int at0, input logic [15:0] d0,
                                input logic [3:0] p0, input logic [3:0] b0,
                                input int at1, input logic [15:0] d1);
        for (int i = 0; i < 16; i++) begin
            int dg;
            dg = i / 4;
            if (i == at0) begin
                load = 1'b1; data = d0; points = p0; blank_mask = b0;
            end else if (i == at1) begin
                load = 1'b1; data = d1; points = p0; blank_mask = b0;
            end else begin
                load = 1'b0;
            end
            step();
            chk($sformatf("w%0d.%0d AN", w, i),   {28'd0, AN},    {28'd0, ~(4'b0001 << dg)});
            chk($sformatf("w%0d.%0d hex", w, i),  {28'd0, hex},   {28'd0, exp_data[dg*4 +: 4]});
            chk($sformatf("w%0d.%0d LE", w, i),   {31'd0, LE},    {31'd0, exp_le[dg]});
            chk($sformatf("w%0d.%0d pt", w, i),   {31'd0, point}, {31'd0, exp_pt[dg]});
            chk($sformatf("w%0d.%0d tick", w, i), {31'd0, frame_tick}, (i == 15) ? 32'd1 : 32'd0);
        end
        load = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        load = 1'b0;
        data = 16'h0;
        points = 4'h0;
        blank_mask = 4'h0;
        zero_blank = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk_reset_outputs($sformatf("rst%0d", i));
        end
        rst = 1'b0;

        // w0: cleared display; load 1A3F mid-frame, must not show until wrap
        check_window(0, 16'h0000, 4'b0000, 4'b0000, 5, 16'h1A3F, 4'b0100, 4'b0000, -1, 16'h0);
        // w1: F,3,A,1 with dp on digit 2; two loads, last one wins
        check_window(1, 16'h1A3F, 4'b0000, 4'b0100, 2, 16'h1111, 4'b0000, 4'b0000, 9, 16'h2222);
        // w2: 2222; load 0005 and enable zero blanking
        zero_blank = 1'b1;
        check_window(2, 16'h2222, 4'b0000, 4'b0000, 3, 16'h0005, 4'b0000, 4'b0000, -1, 16'h0);
        // w3: leading zeros suppressed, nibble values still driven
        check_window(3, 16'h0005, 4'b1110, 4'b0000, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        // w4: zero blanking off live; no reload, value persists; load 1234 with digit-3 blank+dp
        zero_blank = 1'b0;
        check_window(4, 16'h0005, 4'b0000, 4'b0000, 7, 16'h1234, 4'b1000, 4'b1000, -1, 16'h0);
        // w5: digit 3 blanked and its dp forced off; load BEEF in the wrap cycle
        check_window(5, 16'h1234, 4'b1000, 4'b0000, 15, 16'hBEEF, 4'b0000, 4'b0000, -1, 16'h0);
        // w6: BEEF in the immediately following frame
        check_window(6, 16'hBEEF, 4'b0000, 4'b0000, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

        // load mid-frame, then reset before the wrap; also load during reset
        load = 1'b1; data = 16'hCAFE; points = 4'b1111; blank_mask = 4'b0000;
        step();
        load = 1'b0;
        step();
        step();
        rst = 1'b1;
        load = 1'b1; data = 16'h9999;
        step();
        chk_reset_outputs("midrst0");
        load = 1'b0;
        step();
        chk_reset_outputs("midrst1");
        rst = 1'b0;

        // two frames of zeros: the second shows nothing was left pending
        check_window(7, 16'h0000, 4'b0000, 4'b0000, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
        check_window(8, 16'h0000, 4'b0000, 4'b0000, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
